memory_slave_ctrl: RTL and testbench

- Parametrised memory-side controller for bus slaves; successor to the fixed 2K memory slave.
- Sits between the slave protocol core's parallel interface (req/write strobes, address, data) and an inferred single-port synchronous RAM of configurable depth and width.
- Adds a configurable read latency with correct data capture, address range checking, auto-incrementing burst access and a busy handshake.
- The top-level slave wrapper instantiates it once per memory slave.

---
 rtl/memory_slave_pkg.sv | 20 ++
 rtl/memory_slave_ctrl_if.sv | 39 +++
 rtl/mem_sp_ram.sv | 43 ++++
 rtl/memory_slave_ctrl.sv | 163 ++++++++++++++++
 tb/tb_memory_slave_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/memory_slave_pkg.sv
// Shared types and defaults for the memory slave controller and its RAM.
package memory_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_CAP,
        WR,
        DONE
    } state_t;

    localparam int DEF_MEM_DEPTH    = 2048;
    localparam int DEF_READ_LATENCY = 1;

    // Returns the bit that makes the word's total parity even; zero-extend narrower words.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/memory_slave_ctrl_if.sv
// Parallel request/response bundle between the slave protocol core and the memory controller.
// parity_err exists only when MEMORY_SLAVE_PARITY_EN is defined.
interface memory_slave_ctrl_if #(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 8,
    parameter int BURST_WIDTH   = 4
);
    logic                     req_int_data;
    logic                     write_en_internal;
    logic [ADDRESS_WIDTH-1:0] addr_in;
    logic [DATA_WIDTH-1:0]    wdata_in;
    logic [BURST_WIDTH-1:0]   burst_len;
    logic                     module_dv;
    logic [DATA_WIDTH-1:0]    rdata_out;
    logic                     addr_err;
    logic                     busy;
    logic                     burst_active;
    logic [DATA_WIDTH-1:0]    last_data;
`ifdef MEMORY_SLAVE_PARITY_EN
    logic                     parity_err;
`endif

    modport master (
        output req_int_data, write_en_internal, addr_in, wdata_in, burst_len,
        input  module_dv, rdata_out, addr_err, busy, burst_active, last_data
`ifdef MEMORY_SLAVE_PARITY_EN
        , input parity_err
`endif
    );

    modport slave (
        input  req_int_data, write_en_internal, addr_in, wdata_in, burst_len,
        output module_dv, rdata_out, addr_err, busy, burst_active, last_data
`ifdef MEMORY_SLAVE_PARITY_EN
        , output parity_err
`endif
    );

endinterface

// File: rtl/mem_sp_ram.sv
// Single-port synchronous RAM, write-first-free (read and write never share a cycle).
// Latency: READ_LATENCY cycles (1, or 2 with the output register stage).
// Backpressure: none; caller owns sequencing. Contents are never reset.
module mem_sp_ram #(
    parameter int DEPTH        = 2048,
    parameter int WIDTH        = 8,
    parameter int READ_LATENCY = 1,
    parameter int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] q1;

    // q1 only moves on a read, so it holds steady for a late capture.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                q1 <= mem[addr];
            end
        end
    end

    generate
        if (READ_LATENCY > 1) begin : g_oreg
            logic [WIDTH-1:0] q2;
            always_ff @(posedge clk) begin
                q2 <= q1;
            end
            assign rdata = q2;
        end else begin : g_noreg
            assign rdata = q1;
        end
    endgenerate

endmodule

// File: rtl/memory_slave_ctrl.sv
// Memory-side controller for a bus slave: range check, bursts, RAM access; parity via MEMORY_SLAVE_PARITY_EN.
// Latency: read READ_LATENCY+2, write 2, out-of-range 1 cycle from request to module_dv.
// Backpressure: busy high outside IDLE; requests seen while busy are dropped, never queued.
module memory_slave_ctrl
    import memory_slave_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 8,
    parameter int MEM_DEPTH     = DEF_MEM_DEPTH,
    parameter int READ_LATENCY  = DEF_READ_LATENCY,
    parameter int BURST_WIDTH   = 4
) (
    input  logic               clk,
    input  logic               rstn,
    memory_slave_ctrl_if.slave bus
);
    localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
`ifdef MEMORY_SLAVE_PARITY_EN
    localparam int RAM_W = DATA_WIDTH + 1;
`else
    localparam int RAM_W = DATA_WIDTH;
`endif
    localparam logic [ADDRESS_WIDTH:0]   DEPTH_LIM = (ADDRESS_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0]   CNT_ONE   = BURST_WIDTH'(1);
    localparam logic                     WAIT_LAST = 1'(READ_LATENCY - 1);

    state_t                   state_q, state_d;
    logic                     wait_q;
    logic [ADDRESS_WIDTH-1:0] ptr_q, cur_q, eff_addr;
    logic [BURST_WIDTH-1:0]   cnt_q;
    logic                     burst_q, err_q, done;
    logic [DATA_WIDTH-1:0]    rdata_q, last_q;
    logic                     in_range, acc_rd, acc_wr;
    logic                     ram_en, ram_we;
    logic [RAM_W-1:0]         ram_wdata, ram_q;

    // Mid-burst the pointer owns the address; addr_in only seeds a new access.
    assign eff_addr = burst_q ? ptr_q : bus.addr_in;
    assign in_range = {1'b0, eff_addr} < DEPTH_LIM;
    assign acc_rd   = (state_q == IDLE) && bus.req_int_data;
    assign acc_wr   = (state_q == IDLE) && bus.write_en_internal && !bus.req_int_data;
    assign ram_en   = (acc_rd || acc_wr) && in_range;
    assign ram_we   = acc_wr && in_range;
    assign done     = (state_q == DONE);

`ifdef MEMORY_SLAVE_PARITY_EN
    assign ram_wdata = {even_parity(64'(bus.wdata_in)), bus.wdata_in};
`else
    assign ram_wdata = bus.wdata_in;
`endif

    mem_sp_ram #(
        .DEPTH        (MEM_DEPTH),
        .WIDTH        (RAM_W),
        .READ_LATENCY (READ_LATENCY),
        .AW           (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (eff_addr[RAM_AW-1:0]),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= (state_q == RD_WAIT) && (wait_q != WAIT_LAST);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acc_rd) begin
                    state_d = in_range ? RD_WAIT : DONE;
                end else if (acc_wr) begin
                    state_d = in_range ? WR : DONE;
                end
            end
            RD_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = RD_CAP;
                end
            end
            RD_CAP:  state_d = DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef MEMORY_SLAVE_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            par_q <= 1'b0;
        end else if (acc_rd || acc_wr) begin
            par_q <= 1'b0;
        end else if (state_q == RD_CAP) begin
            par_q <= even_parity(64'(ram_q));
        end
    end

    assign bus.parity_err = done && par_q;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q   <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            burst_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            last_q  <= '0;
        end else begin
            if (acc_rd || acc_wr) begin
                err_q <= !in_range;
                cur_q <= eff_addr;
                // An out-of-range first word never opens a burst, so later words cannot fault.
                if (!burst_q && in_range && (bus.burst_len != '0)) begin
                    burst_q <= 1'b1;
                    cnt_q   <= bus.burst_len;
                end
                if (acc_rd && !in_range) begin
                    rdata_q <= '0;
                end
                if (acc_wr && in_range) begin
                    last_q <= bus.wdata_in;
                end
            end
            if (state_q == RD_CAP) begin
                rdata_q <= ram_q[DATA_WIDTH-1:0];
                last_q  <= ram_q[DATA_WIDTH-1:0];
            end
            if (done && burst_q) begin
                ptr_q <= (cur_q == LAST_ADDR) ? '0 : cur_q + ADDR_ONE;
                if (cnt_q == '0) begin
                    burst_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - CNT_ONE;
                end
            end
        end
    end

    assign bus.module_dv    = done;
    assign bus.addr_err     = done && err_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.burst_active = burst_q;
    assign bus.rdata_out    = rdata_q;
    assign bus.last_data    = last_q;

endmodule

// File: tb/tb_memory_slave_ctrl.sv
// Directed bench for memory_slave_ctrl: one instance at read latency 1, one at read latency 2.
// Parity checks are compiled in only when MEMORY_SLAVE_PARITY_EN is defined.
module tb_memory_slave_ctrl;
    logic clk = 1'b0;
    logic rstn1, rstn2;
    int   n_chk = 0;
    int   n_bad = 0;
    int   lat;
    int   pulses;

    always #5 clk = ~clk;

    memory_slave_ctrl_if #(.ADDRESS_WIDTH(15), .DATA_WIDTH(8), .BURST_WIDTH(4)) if1 ();
    memory_slave_ctrl_if #(.ADDRESS_WIDTH(15), .DATA_WIDTH(8), .BURST_WIDTH(4)) if2 ();

    memory_slave_ctrl #(.READ_LATENCY(1)) d1 (.clk(clk), .rstn(rstn1), .bus(if1));
    memory_slave_ctrl #(.READ_LATENCY(2)) d2 (.clk(clk), .rstn(rstn2), .bus(if2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s2, input bit rd, input bit wr, input logic [14:0] a,
                         input logic [7:0] wd, input logic [3:0] bl);
        if (s2) begin
            if2.req_int_data = rd; if2.write_en_internal = wr;
            if2.addr_in = a; if2.wdata_in = wd; if2.burst_len = bl;
        end else begin
            if1.req_int_data = rd; if1.write_en_internal = wr;
            if1.addr_in = a; if1.wdata_in = wd; if1.burst_len = bl;
        end
    endtask

    function automatic logic busy_of(input bit s2);
        return s2 ? if2.busy : if1.busy;
    endfunction

    function automatic logic dv_of(input bit s2);
        return s2 ? if2.module_dv : if1.module_dv;
    endfunction

    task automatic wait_idle(input bit s2);
        int k = 0;
        while (busy_of(s2) && k < 20) begin
            tick();
            k++;
        end
    endtask

    // One-cycle request; returns in the module_dv cycle with the cycle count since the request.
    task automatic access(input bit s2, input bit rd, input bit wr, input logic [14:0] a,
                          input logic [7:0] wd, input logic [3:0] bl, output int n);
        wait_idle(s2);
        drive(s2, rd, wr, a, wd, bl);
        tick();
        drive(s2, 1'b0, 1'b0, 15'h0, 8'h0, 4'h0);
        n = 1;
        while (!dv_of(s2) && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rstn1 = 1'b0;
        rstn2 = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 15'h0, 8'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 15'h0, 8'h0, 4'h0);
        repeat (3) tick();
        chk("rst_dv",     32'(if1.module_dv),    0);
        chk("rst_busy",   32'(if1.busy),         0);
        chk("rst_burst",  32'(if1.burst_active), 0);
        chk("rst_err",    32'(if1.addr_err),     0);
        chk("rst_rdata",  32'(if1.rdata_out),    0);
        chk("rst_last",   32'(if1.last_data),    0);
        rstn1 = 1'b1;
        rstn2 = 1'b1;
        tick();

        // write then read back, latency 1
        access(1'b0, 1'b0, 1'b1, 15'h010, 8'hA5, 4'h0, lat);
        chk("wr_lat",     32'(lat), 2);
        chk("wr_err",     32'(if1.addr_err),  0);
        chk("wr_last",    32'(if1.last_data), 32'hA5);
        access(1'b0, 1'b1, 1'b0, 15'h010, 8'h00, 4'h0, lat);
        chk("rd_lat",     32'(lat), 3);
        chk("rd_data",    32'(if1.rdata_out), 32'hA5);
        chk("rd_err",     32'(if1.addr_err),  0);

        // first out-of-range word
        access(1'b0, 1'b1, 1'b0, 15'h0800, 8'h00, 4'h0, lat);
        chk("oor_lat",    32'(lat), 1);
        chk("oor_err",    32'(if1.addr_err),  1);
        chk("oor_rdata",  32'(if1.rdata_out), 0);
        chk("oor_busy",   32'(if1.busy),      1);
        tick();
        chk("oor_busy_after", 32'(if1.busy),     0);
        chk("oor_err_after",  32'(if1.addr_err), 0);

        // burst write across the top of memory; later addr_in values must be ignored
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 1'b0, 1'b1, (i == 0) ? 15'h07FE : 15'h0555, 8'(i + 1),
                   (i == 0) ? 4'h3 : 4'h0, lat);
            chk($sformatf("bwr_lat%0d", i),   32'(lat), 2);
            chk($sformatf("bwr_act%0d", i),   32'(if1.burst_active), 1);
            chk($sformatf("bwr_err%0d", i),   32'(if1.addr_err), 0);
        end
        tick();
        chk("bwr_act_end", 32'(if1.burst_active), 0);
        begin
            logic [14:0] ba [4];
            ba[0] = 15'h07FE; ba[1] = 15'h07FF; ba[2] = 15'h0000; ba[3] = 15'h0001;
            for (int i = 0; i < 4; i++) begin
                access(1'b0, 1'b1, 1'b0, ba[i], 8'h00, 4'h0, lat);
                chk($sformatf("brd_data%0d", i), 32'(if1.rdata_out), 32'(i + 1));
            end
        end

        // read wins over a simultaneous write
        access(1'b0, 1'b0, 1'b1, 15'h020, 8'h11, 4'h0, lat);
        access(1'b0, 1'b1, 1'b1, 15'h020, 8'h99, 4'h0, lat);
        chk("both_lat",   32'(lat), 3);
        chk("both_data",  32'(if1.rdata_out), 32'h11);
        access(1'b0, 1'b1, 1'b0, 15'h020, 8'h00, 4'h0, lat);
        chk("both_reread", 32'(if1.rdata_out), 32'h11);

        // a write pulsed while busy is dropped and yields no extra completion
        wait_idle(1'b0);
        drive(1'b0, 1'b1, 1'b0, 15'h010, 8'h00, 4'h0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 15'h010, 8'hEE, 4'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 15'h0, 8'h0, 4'h0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (if1.module_dv) pulses++;
            tick();
        end
        chk("busy_drop_dv", 32'(pulses), 1);
        access(1'b0, 1'b1, 1'b0, 15'h010, 8'h00, 4'h0, lat);
        chk("busy_drop_data", 32'(if1.rdata_out), 32'hA5);

        // read latency 2 instance
        access(1'b1, 1'b0, 1'b1, 15'h040, 8'h3C, 4'h0, lat);
        chk("l2_wr_lat",  32'(lat), 2);
        access(1'b1, 1'b1, 1'b0, 15'h040, 8'h00, 4'h0, lat);
        chk("l2_rd_lat",  32'(lat), 4);
        chk("l2_rd_data", 32'(if2.rdata_out), 32'h3C);

        // reset during RD_WAIT abandons the read
        wait_idle(1'b1);
        drive(1'b1, 1'b1, 1'b0, 15'h040, 8'h00, 4'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 15'h0, 8'h0, 4'h0);
        chk("mid_busy",   32'(if2.busy), 1);
        rstn2 = 1'b0;
        tick();
        rstn2 = 1'b1;
        chk("mid_rst_busy", 32'(if2.busy), 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (if2.module_dv) pulses++;
            tick();
        end
        chk("mid_rst_dv", 32'(pulses), 0);
        access(1'b1, 1'b1, 1'b0, 15'h040, 8'h00, 4'h0, lat);
        chk("mid_rst_ram", 32'(if2.rdata_out), 32'h3C);

`ifdef MEMORY_SLAVE_PARITY_EN
        access(1'b0, 1'b0, 1'b1, 15'h050, 8'h5A, 4'h0, lat);
        access(1'b0, 1'b1, 1'b0, 15'h050, 8'h00, 4'h0, lat);
        chk("par_clean",  32'(if1.parity_err), 0);
        wait_idle(1'b0);
        d1.u_ram.mem[80] = d1.u_ram.mem[80] ^ 9'h001;
        access(1'b0, 1'b1, 1'b0, 15'h050, 8'h00, 4'h0, lat);
        chk("par_dv",     32'(if1.module_dv),  1);
        chk("par_err",    32'(if1.parity_err), 1);
        chk("par_raw",    32'(if1.rdata_out),  32'h5B);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
